// File: rtl/fib_req_sched.sv
// fib_req_sched: round-robin scheduler sharing one iterative Fibonacci engine
// between NUM_REQ requesters. One transaction in flight; the result is returned
// tagged with the requester id and the echoed index.
// Optional build macro FIB_SAT_EN: saturate results whose F(n) overflowed DATA_W.
module fib_req_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [6*NUM_REQ-1:0]  req_n,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [5:0]            rsp_n,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic [ID_W-1:0]     rr_ptr_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [5:0]          cnt_r;
  logic [ID_W-1:0]     id_r;
  logic [5:0]          n_r;
  logic                rsp_valid_r;
  logic [ID_W-1:0]     rsp_id_r;
  logic [5:0]          rsp_n_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                busy_r;
`ifdef FIB_SAT_EN
  logic                ovf_a_r;
  logic                ovf_b_r;
`endif

  logic                gnt_found_s;
  logic [ID_W-1:0]     gnt_id_s;
  logic [5:0]          gnt_n_s;
  logic [DATA_W:0]     sum_s;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : arb
    int idx;
    gnt_found_s = 1'b0;
    gnt_id_s    = '0;
    idx         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!gnt_found_s && req_valid[idx]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = idx[ID_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    gnt_n_s = req_n[int'(gnt_id_s)*6 +: 6];
  end

  // One-hot accept, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (state_r == ST_IDLE) && gnt_found_s && rst_n &&
                     (gnt_id_s == ID_W'(i));
    end
  end

  // Add step with carry-out kept for the overflow tracking.
  always_comb begin
    sum_s = {1'b0, a_r} + {1'b0, b_r};
  end

  // Scheduler FSM and Fibonacci datapath with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= '0;
      a_r         <= DATA_W'(1);
      b_r         <= '0;
      cnt_r       <= 6'd0;
      id_r        <= '0;
      n_r         <= 6'd0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_n_r     <= 6'd0;
      rsp_data_r  <= '0;
      busy_r      <= 1'b0;
`ifdef FIB_SAT_EN
      ovf_a_r     <= 1'b0;
      ovf_b_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt_found_s) begin
            id_r   <= gnt_id_s;
            n_r    <= gnt_n_s;
            a_r    <= DATA_W'(1);
            b_r    <= '0;
            cnt_r  <= gnt_n_s;
            busy_r <= 1'b1;
`ifdef FIB_SAT_EN
            ovf_a_r <= 1'b0;
            ovf_b_r <= 1'b0;
`endif
            if (gnt_id_s == ID_W'(NUM_REQ - 1)) begin
              rr_ptr_r <= '0;
            end else begin
              rr_ptr_r <= gnt_id_s + ID_W'(1);
            end
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt_r != 6'd0) begin
            a_r   <= sum_s[DATA_W-1:0];
            b_r   <= a_r;
            cnt_r <= cnt_r - 6'd1;
`ifdef FIB_SAT_EN
            ovf_b_r <= ovf_a_r;
            ovf_a_r <= ovf_a_r | sum_s[DATA_W];
`endif
          end else begin
`ifdef FIB_SAT_EN
            // Saturate only when F(n) itself wrapped, not F(n+1) held in A.
            rsp_data_r <= ovf_b_r ? {DATA_W{1'b1}} : b_r;
`else
            rsp_data_r <= b_r;
`endif
            rsp_id_r    <= id_r;
            rsp_n_r     <= n_r;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_n     = rsp_n_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;

endmodule
